// File: rtl/seq_shift_add_multiplier.sv
// rtl/seq_shift_add_multiplier.sv - iterative shift-add WIDTH x WIDTH multiplier with start/busy/done handshake
// Optional two's-complement operands when SIGNED_MODE_EN is defined.
module seq_shift_add_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iStart,
  input  logic [WIDTH-1:0]   iData_A,
  input  logic [WIDTH-1:0]   iData_B,
`ifdef SIGNED_MODE_EN
  input  logic               iSigned,
`endif
  output logic               oBusy,
  output logic               oDone,
  output logic [2*WIDTH-1:0] oProd
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [2*WIDTH-1:0] r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;

  logic               load;
  logic               last_iter;
  logic [2*WIDTH-1:0] sum_next;
  logic [2*WIDTH-1:0] final_prod;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;

  assign load      = iStart && ((state == IDLE) || (state == DONE));
  assign last_iter = (state == CALC) && (r_cnt == LAST_ITER);
  assign sum_next  = r_b[0] ? (r_acc + r_a) : r_acc;

`ifdef SIGNED_MODE_EN
  logic r_sign;
  logic sign_in;

  // Magnitudes are held unsigned, so the most negative operand maps to 2^(WIDTH-1).
  assign mag_a      = (iSigned && iData_A[WIDTH-1]) ? (~iData_A + 1'b1) : iData_A;
  assign mag_b      = (iSigned && iData_B[WIDTH-1]) ? (~iData_B + 1'b1) : iData_B;
  assign sign_in    = iSigned && (iData_A[WIDTH-1] ^ iData_B[WIDTH-1]);
  assign final_prod = r_sign ? (~sum_next + 1'b1) : sum_next;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_sign <= 1'b0;
    end else if (load) begin
      r_sign <= sign_in;
    end
  end
`else
  assign mag_a      = iData_A;
  assign mag_b      = iData_B;
  assign final_prod = sum_next;
`endif

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (iStart) state_next = CALC;
      end
      CALC: begin
        if (last_iter) state_next = DONE;
      end
      DONE: begin
        state_next = iStart ? CALC : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Fixed WIDTH iterations regardless of operand values; no early exit.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (load) begin
      r_a   <= {{WIDTH{1'b0}}, mag_a};
      r_b   <= mag_b;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (state == CALC) begin
      r_acc <= sum_next;
      r_a   <= r_a << 1;
      r_b   <= r_b >> 1;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      oProd <= '0;
    end else if (last_iter) begin
      oProd <= final_prod;
    end
  end

  assign oBusy = (state == CALC);
  assign oDone = (state == DONE);

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// tb/tb_seq_shift_add_multiplier.sv - self-checking bench for seq_shift_add_multiplier (WIDTH=32)
// Define SIGNED_MODE_EN to also exercise signed operands.
module tb_seq_shift_add_multiplier;

  localparam int W = 32;

  logic         Clock;
  logic         Reset;
  logic         iStart;
  logic [W-1:0] iData_A;
  logic [W-1:0] iData_B;
  logic         iSigned;
  logic         oBusy;
  logic         oDone;
  logic [2*W-1:0] oProd;

  int tests_run;
  int tests_failed;

  seq_shift_add_multiplier #(.WIDTH(W)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .iStart  (iStart),
    .iData_A (iData_A),
    .iData_B (iData_B),
`ifdef SIGNED_MODE_EN
    .iSigned (iSigned),
`endif
    .oBusy   (oBusy),
    .oDone   (oDone),
    .oProd   (oProd)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = s ? {{32{a[31]}}, a} : {32'd0, a};
    eb = s ? {{32{b[31]}}, b} : {32'd0, b};
    return ea * eb;
  endfunction

  // Stimulus only: issues one request, waits for oDone, reports what it saw.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [63:0] p, output int busy, output bit got_done);
    @(negedge Clock);
    iStart = 1'b1; iData_A = a; iData_B = b; iSigned = s;
    @(posedge Clock);
    #1;
    iStart = 1'b0; iData_A = $urandom; iData_B = $urandom; iSigned = 1'b0;
    busy = 0; got_done = 1'b0;
    for (int i = 0; i < 100 && !got_done; i++) begin
      @(negedge Clock);
      if (oDone) got_done = 1'b1;
      else if (oBusy) busy++;
    end
    p = oProd;
  endtask

  task automatic test_reset;
    Reset = 1'b0; iStart = 1'b1; iData_A = 32'd3; iData_B = 32'd5; iSigned = 1'b0;
    repeat (3) @(negedge Clock);
    tests_run++;
    if (oBusy !== 1'b0 || oDone !== 1'b0 || oProd !== 64'd0) begin
      tests_failed++;
      $display("FAIL reset_state: busy=%b done=%b prod=%h required 0 0 0", oBusy, oDone, oProd);
    end
    iStart = 1'b0;
    Reset = 1'b1;
    repeat (2) @(negedge Clock);
    tests_run++;
    if (oBusy !== 1'b0 || oDone !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_after_reset: busy=%b done=%b required 0 0", oBusy, oDone);
    end
  endtask

  task automatic test_directed;
    logic [31:0] av [3] = '{32'd3, 32'hFFFFFFFF, 32'd0};
    logic [31:0] bv [3] = '{32'd5, 32'hFFFFFFFF, 32'h1234};
    logic [63:0] ev [3] = '{64'd15, 64'hFFFFFFFE00000001, 64'd0};
    logic [63:0] p;
    int busy;
    bit got;
    for (int k = 0; k < 3; k++) begin
      do_op(av[k], bv[k], 1'b0, p, busy, got);
      tests_run++;
      if (!got || p !== ev[k]) begin
        tests_failed++;
        $display("FAIL directed_%0d: done=%0d prod=%h required %h", k, got, p, ev[k]);
      end
      tests_run++;
      if (busy != W || oBusy !== 1'b0) begin
        tests_failed++;
        $display("FAIL latency_%0d: busy_cycles=%0d busy_in_done=%b required %0d 0", k, busy, oBusy, W);
      end
      @(negedge Clock);
      tests_run++;
      if (oDone !== 1'b0) begin
        tests_failed++;
        $display("FAIL done_pulse_%0d: done=%b required 0", k, oDone);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a1, b1, a2, b2;
    bit got;
    int busy;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
    @(negedge Clock);
    iStart = 1'b1; iData_A = a1; iData_B = b1; iSigned = 1'b0;
    @(posedge Clock);
    #1;
    iData_A = a2; iData_B = b2;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge Clock);
      if (oDone) got = 1'b1;
    end
    tests_run++;
    if (!got || oProd !== ref_mul(a1, b1, 1'b0)) begin
      tests_failed++;
      $display("FAIL start_ignored_in_calc: done=%0d prod=%h required %h", got, oProd, ref_mul(a1, b1, 1'b0));
    end
    @(posedge Clock);
    #1;
    iStart = 1'b0; iData_A = $urandom; iData_B = $urandom;
    @(negedge Clock);
    tests_run++;
    if (oBusy !== 1'b1) begin
      tests_failed++;
      $display("FAIL back_to_back_no_gap: busy=%b required 1", oBusy);
    end
    busy = 1; got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge Clock);
      if (oDone) got = 1'b1;
      else if (oBusy) busy++;
    end
    tests_run++;
    if (!got || busy != W || oProd !== ref_mul(a2, b2, 1'b0)) begin
      tests_failed++;
      $display("FAIL back_to_back_second: done=%0d busy=%0d prod=%h required 1 %0d %h",
               got, busy, oProd, W, ref_mul(a2, b2, 1'b0));
    end
  endtask

  task automatic test_reset_abort;
    logic [63:0] p;
    int busy;
    bit got;
    @(negedge Clock);
    iStart = 1'b1; iData_A = 32'd11; iData_B = 32'd13; iSigned = 1'b0;
    @(posedge Clock);
    #1;
    iStart = 1'b0;
    repeat (10) @(negedge Clock);
    #2;
    Reset = 1'b0;
    #1;
    tests_run++;
    if (oBusy !== 1'b0 || oDone !== 1'b0 || oProd !== 64'd0) begin
      tests_failed++;
      $display("FAIL async_abort: busy=%b done=%b prod=%h required 0 0 0", oBusy, oDone, oProd);
    end
    @(negedge Clock);
    Reset = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clock);
      if (oDone || oBusy) got = 1'b1;
    end
    tests_run++;
    if (got) begin
      tests_failed++;
      $display("FAIL no_done_after_abort: activity=1 required 0");
    end
    do_op(32'd7, 32'd9, 1'b0, p, busy, got);
    tests_run++;
    if (!got || p !== 64'd63) begin
      tests_failed++;
      $display("FAIL fresh_after_abort: done=%0d prod=%h required %h", got, p, 64'd63);
    end
  endtask

`ifdef SIGNED_MODE_EN
  task automatic test_signed;
    logic [31:0] av [3] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] bv [3] = '{32'd7, 32'h80000000, 32'hFFFFFFFF};
    logic        sv [3] = '{1'b1, 1'b1, 1'b0};
    logic [63:0] ev [3] = '{64'hFFFFFFFFFFFFFFEB, 64'h4000000000000000, 64'hFFFFFFFE00000001};
    logic [63:0] p;
    int busy;
    bit got;
    for (int k = 0; k < 3; k++) begin
      do_op(av[k], bv[k], sv[k], p, busy, got);
      tests_run++;
      if (!got || p !== ev[k] || busy != W) begin
        tests_failed++;
        $display("FAIL signed_%0d: done=%0d busy=%0d prod=%h required %h", k, got, busy, p, ev[k]);
      end
    end
  endtask
`endif

  task automatic test_random;
    logic [31:0] a, b;
    logic        s;
    logic [63:0] p;
    int busy;
    bit got;
    int errs;
    errs = 0;
    for (int n = 0; n < 250; n++) begin
      case ($urandom_range(0, 3))
        0: a = 32'h80000000 | $urandom;
        1: a = $urandom_range(0, 15);
        default: a = $urandom;
      endcase
      b = $urandom;
`ifdef SIGNED_MODE_EN
      s = $urandom_range(0, 1) == 1;
`else
      s = 1'b0;
`endif
      do_op(a, b, s, p, busy, got);
      tests_run++;
      if (!got || p !== ref_mul(a, b, s) || busy != W) begin
        tests_failed++;
        errs++;
        if (errs <= 10)
          $display("FAIL random_%0d: a=%h b=%h s=%b done=%0d busy=%0d prod=%h required %h",
                   n, a, b, s, got, busy, p, ref_mul(a, b, s));
      end
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_abort();
`ifdef SIGNED_MODE_EN
    test_signed();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
